// File: rtl/timer_dev.sv
// timer_dev: memory-mapped programmable down-counter timer with one-shot and auto-reload modes
// Ports: clk, reset (async, active-high), Addr/WD/Wr from the system bridge,
//        RD combinational read data back to the bridge, IRQ = IM & expiry flag.
// Map (Addr[3:2]): 0 CTRL {IM,Mode[1:0],En}, 1 PRESET, 2 COUNT (RO), 3 reserved.
module timer_dev #(
  parameter int ADDR_WD = 4
) (
  input  logic               clk,
  input  logic               reset,
  input  logic [ADDR_WD-1:0] Addr,
  input  logic [31:0]        WD,
  input  logic               Wr,
  output logic [31:0]        RD,
  output logic               IRQ
);
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_CNT, S_INT} state_t;
  state_t      r_state;
  logic [3:0]  r_ctrl;
  logic [31:0] r_preset;
  logic [31:0] r_count;
  logic        r_flag;
  logic [1:0]  w_sel;
  logic        w_wr_ctrl;
  logic        w_wr_pre;
  logic        w_expire;
  logic        w_reload;
  logic        w_unused;
  assign w_sel     = Addr[3:2];
  assign w_wr_ctrl = Wr && w_sel == 2'd0;
  assign w_wr_pre  = Wr && w_sel == 2'd1;
  assign w_expire  = r_state == S_CNT && r_ctrl[0] && r_count == '0;
  assign w_reload  = r_state == S_INT && r_ctrl[2:1] == 2'd1;
  assign w_unused  = &{1'b0, Addr};
  assign RD  = w_sel == 2'd0 ? {28'b0, r_ctrl} :
               w_sel == 2'd1 ? r_preset :
               w_sel == 2'd2 ? r_count : '0;
  assign IRQ = r_ctrl[3] & r_flag;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state  <= S_IDLE;
      r_ctrl   <= '0;
      r_preset <= '0;
      r_count  <= '0;
      r_flag   <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: r_state <= r_ctrl[0] ? S_LOAD : S_IDLE;
        S_LOAD: begin
          r_count <= r_preset;
          r_state <= S_CNT;
        end
        S_CNT: begin
          if (!r_ctrl[0]) r_state <= S_IDLE;
          else if (r_count == '0) r_state <= S_INT;
          else r_count <= r_count - 32'd1;
        end
        default: begin
          r_state <= w_reload ? S_LOAD : S_IDLE;
          if (!w_reload) r_ctrl[0] <= 1'b0;
        end
      endcase
      // a software CTRL write lands after the hardware En clear so it wins;
      // an expiry in the same cycle as a CTRL write still sets the flag
      r_flag <= w_expire ? 1'b1 : (w_wr_ctrl || w_reload) ? 1'b0 : r_flag;
      if (w_wr_ctrl) r_ctrl <= WD[3:0];
      if (w_wr_pre) r_preset <= WD;
    end
  end
endmodule

// File: tb/tb_timer_dev.sv
// tb_timer_dev: randomized and directed self-checking bench for timer_dev
module tb_timer_dev;
  logic        clk;
  logic        reset;
  logic [3:0]  Addr;
  logic [31:0] WD;
  logic        Wr;
  logic [31:0] RD;
  logic        IRQ;
  int n_checks = 0;
  int n_errors = 0;
  timer_dev #(.ADDR_WD(4)) dut (
    .clk(clk), .reset(reset), .Addr(Addr), .WD(WD), .Wr(Wr), .RD(RD), .IRQ(IRQ)
  );
  initial clk = 1'b0;
  always #5 clk = ~clk;
  // reference: software-visible registers plus where the timer is in its cycle
  localparam int IDLE = 0, LOADING = 1, RUNNING = 2, EXPIRED = 3;
  logic [3:0]  m_ctrl;
  logic [31:0] m_pre;
  logic [31:0] m_cnt;
  logic        m_flag;
  int          m_where;
  task automatic model_reset();
    m_ctrl = '0; m_pre = '0; m_cnt = '0; m_flag = 1'b0; m_where = IDLE;
  endtask
  function automatic logic [31:0] m_rd(input logic [3:0] a);
    return a[3:2] == 2'd0 ? {28'b0, m_ctrl} : a[3:2] == 2'd1 ? m_pre : a[3:2] == 2'd2 ? m_cnt : 32'd0;
  endfunction
  task automatic model_step(input logic wr, input logic [3:0] a, input logic [31:0] d);
    bit running = m_ctrl[0];
    bit periodic = m_ctrl[2:1] == 2'd1;
    bit fires = m_where == RUNNING && running && m_cnt == 0;
    int next_where = m_where;
    if (m_where == IDLE && running) next_where = LOADING;
    if (m_where == LOADING) begin
      m_cnt = m_pre;
      next_where = RUNNING;
    end
    if (m_where == RUNNING) begin
      if (!running) next_where = IDLE;
      else if (fires) next_where = EXPIRED;
      else m_cnt = m_cnt - 1;
    end
    if (m_where == EXPIRED) begin
      next_where = periodic ? LOADING : IDLE;
      if (periodic) m_flag = 1'b0;
      else m_ctrl[0] = 1'b0;
    end
    if (wr && a[3:2] == 2'd0) begin
      m_ctrl = d[3:0];
      m_flag = 1'b0;
    end
    if (wr && a[3:2] == 2'd1) m_pre = d;
    if (fires) m_flag = 1'b1;
    m_where = next_where;
  endtask
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask
  task automatic tick();
    model_step(Wr, Addr, WD);
    @(posedge clk);
    #1;
    chk("irq", 32'(IRQ), 32'(m_ctrl[3] & m_flag));
    chk("rd", RD, m_rd(Addr));
  endtask
  task automatic wr(input logic [3:0] a, input logic [31:0] d);
    Wr = 1'b1; Addr = a; WD = d;
    tick();
    Wr = 1'b0;
  endtask
  task automatic rd_chk(input string tag, input logic [3:0] a, input logic [31:0] exp);
    Addr = a;
    #1;
    chk(tag, RD, exp);
  endtask
  task automatic apply_reset();
    #2 reset = 1'b1;
    for (int a = 0; a < 4; a++) begin
      Addr = 4'(a * 4);
      #1;
      chk("rst_rd", RD, 32'd0);
    end
    chk("rst_irq", 32'(IRQ), 32'd0);
    model_reset();
    @(posedge clk);
    #1 reset = 1'b0;
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end
  initial begin
    reset = 1'b1; Wr = 1'b0; Addr = '0; WD = '0;
    model_reset();
    apply_reset();
    // reset mid-count
    wr(4'd4, 32'd100);
    wr(4'd0, 32'h9);
    repeat (52) tick();
    rd_chk("pre_rst_cnt", 4'd8, 32'd50);
    apply_reset();
    repeat (3) tick();
    rd_chk("post_rst_cnt", 4'd8, 32'd0);
    rd_chk("post_rst_ctrl", 4'd0, 32'd0);
    chk("post_rst_irq", 32'(IRQ), 32'd0);
    // one-shot
    apply_reset();
    wr(4'd4, 32'd5);
    wr(4'd0, 32'h9);
    tick();
    for (int k = 0; k < 6; k++) begin
      tick();
      rd_chk("os_cnt", 4'd8, 32'(5 - k));
      chk("os_irq_lo", 32'(IRQ), 32'd0);
    end
    tick();
    chk("os_irq_hi", 32'(IRQ), 32'd1);
    tick();
    rd_chk("os_ctrl", 4'd0, 32'h8);
    chk("os_irq_hold", 32'(IRQ), 32'd1);
    wr(4'd0, 32'h8);
    chk("os_irq_clr", 32'(IRQ), 32'd0);
    // auto-reload, PRESET changed mid-period
    apply_reset();
    wr(4'd4, 32'd3);
    wr(4'd0, 32'hB);
    for (int i = 1; i <= 40; i++) begin
      Wr = i == 27; Addr = i == 27 ? 4'd4 : 4'd8; WD = 32'd1;
      tick();
      chk("ar_irq", 32'(IRQ), 32'(i == 6 || i == 12 || i == 18 || i == 24 || i == 30 || i == 34 || i == 38));
    end
    Wr = 1'b0;
    // masking
    apply_reset();
    wr(4'd4, 32'd2);
    wr(4'd0, 32'h1);
    repeat (8) begin
      tick();
      chk("mask_irq", 32'(IRQ), 32'd0);
    end
    wr(4'd0, 32'h8);
    chk("mask_clr", 32'(IRQ), 32'd0);
    wr(4'd0, 32'h9);
    for (int i = 1; i <= 5; i++) begin
      tick();
      chk("mask_rerun", 32'(IRQ), 32'(i == 5));
    end
    // pause, bus boundaries, resume
    apply_reset();
    wr(4'd4, 32'd10);
    wr(4'd0, 32'h9);
    repeat (5) tick();
    wr(4'd0, 32'h8);
    repeat (2) tick();
    rd_chk("pause_cnt", 4'd8, 32'd6);
    wr(4'd8, 32'hDEAD);
    rd_chk("ro_cnt", 4'd8, 32'd6);
    wr(4'd12, 32'hDEAD);
    rd_chk("rsv_rd", 4'd12, 32'd0);
    Addr = 4'd4; WD = 32'h55;
    tick();
    rd_chk("nowr_pre", 4'd4, 32'd10);
    Addr = 4'd0; WD = 32'hF;
    tick();
    rd_chk("nowr_ctrl", 4'd0, 32'h8);
    wr(4'd0, 32'h9);
    for (int i = 1; i <= 13; i++) begin
      tick();
      chk("resume_irq", 32'(IRQ), 32'(i == 13));
      if (i == 2) rd_chk("resume_cnt", 4'd8, 32'd10);
    end
    // PRESET = 0
    apply_reset();
    wr(4'd0, 32'h9);
    for (int i = 1; i <= 3; i++) begin
      tick();
      chk("p0_irq", 32'(IRQ), 32'(i == 3));
    end
    // randomized traffic against the reference
    apply_reset();
    for (int i = 0; i < 600; i++) begin
      Wr = $urandom_range(0, 3) == 0;
      Addr = 4'($urandom_range(0, 15));
      WD = $urandom;
      if (Addr[3:2] == 2'd1) WD = $urandom_range(0, 6);
      if (Addr[3:2] == 2'd0) WD[0] = $urandom_range(0, 3) != 0;
      tick();
    end
    Wr = 1'b0;
    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule

// File: doc/timer_dev.md
Name: timer_dev

Overview:
- Memory-mapped programmable down-counter timer.
- Acts as one slave device on the processor's system bridge: it receives a device-local address, write data and its own write-enable from the bridge, and returns read data to it.
- Counts down from a software-loaded preset and raises an interrupt request on expiry.
- Supports one-shot and auto-reload (periodic) modes.

Parameters:
- ADDR_WD, 4, width of the device-local byte address supplied by the bridge; registers are decoded from Addr[3:2], higher bits ignored.

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- reset  input  1  asynchronous, active-high reset.
- Addr  input  ADDR_WD  device-local byte address from bridge.
- WD  input  32  write data from bridge.
- Wr  input  1  write enable (this device's bit of the bridge's per-device write vector).
- RD  output  32  read data to bridge (combinational).
- IRQ  output  1  interrupt request to CPU.

Behaviour:
- Register map, selected by Addr[3:2]:
  - 0 CTRL (R/W): bit0 En, bits2:1 Mode, bit3 IM; bits 31:4 read 0 and are not stored.
  - 1 PRESET (R/W): 32 bits.
  - 2 COUNT (RO): writes ignored.
  - 3 reserved: reads 0, writes ignored.
- Reads: RD = selected register, purely combinational, zero latency; unaffected by Wr.
- Writes: take effect at the rising edge where Wr=1.
  - PRESET write does not disturb a count in progress; it is used at the next LOAD.
- Reset (asynchronous, any time, including mid-count):
  - CTRL=0, PRESET=0, COUNT=0, irq flag=0, state=IDLE.
  - IRQ=0 and RD reflects the zeroed registers immediately.
- FSM states IDLE, LOAD, CNT, INT; one transition per clock:
  - IDLE: En=1 -> LOAD; otherwise stay.
  - LOAD: COUNT<=PRESET; -> CNT.
  - CNT, checked in priority order:
    - En=0 -> IDLE; COUNT holds its value.
    - COUNT==0 -> INT; irq flag<=1.
    - otherwise COUNT<=COUNT-1.
  - INT:
    - Mode=0 (one-shot): hardware clears CTRL.En; -> IDLE; irq flag stays 1.
    - Mode=1 (auto-reload): -> LOAD; irq flag<=0, so the flag is high for exactly one cycle.
    - Mode=2/3: handled as Mode=0.
- Mode changes while running take effect at the next INT.
- IRQ = IM & irq flag, combinational from registered state.
- irq flag clear conditions:
  - any CTRL write clears it, including a write of the same value;
  - in Mode 1 it also clears on INT->LOAD.
- Simultaneous events:
  - CTRL write in the same cycle as the INT-state hardware En clear: the software-written value wins.
  - CTRL write in the same cycle as flag set (CNT->INT): set wins.
- COUNT never wraps: decrement happens only when COUNT!=0.
- Timing with PRESET=N, En written at edge e1:
  - IDLE->LOAD at e2; COUNT=N at e3.
  - COUNT reaches 0 at e(3+N); INT and flag=1 at e(4+N).
  - Latency from write edge to IRQ is N+3 cycles.
  - Mode 1 period is N+3 cycles (flag high one cycle per period).
- PRESET=0: LOAD->CNT->INT; flag set 2 cycles after LOAD.
- Clearing En while in LOAD: LOAD still completes (COUNT<=PRESET), then CNT sees En=0 -> IDLE.

Test Plan:
- Reset mid-count (PRESET=100, running, assert reset at count 50) -> immediately RD of COUNT/CTRL/PRESET = 0 and IRQ=0; after release, stays IDLE with COUNT=0.
- One-shot: write PRESET=5, then CTRL=0x9 (En=1, Mode=0, IM=1) -> COUNT sequence 5,4,3,2,1,0; IRQ rises 8 cycles after CTRL write edge; CTRL reads 0x8; IRQ stays high until CTRL write of 0x8 -> IRQ=0 next cycle.
- Auto-reload: PRESET=3, CTRL=0xB -> IRQ pulses one cycle wide every 6 cycles for at least 4 periods; a PRESET=1 write mid-period changes the period to 4 only after the next LOAD.
- Masking: PRESET=2, CTRL=0x1 (IM=0) -> IRQ stays 0 and the flag is set; write CTRL=0x8 then 0x9 -> flag cleared by first write, so no IRQ until the next expiry.
- Pause and resume: PRESET=10, start, write CTRL=0x0 when COUNT=6 -> COUNT holds 6; rewrite CTRL=0x1 -> reload to 10 via IDLE->LOAD, and expiry is 13 cycles later.
- Bus boundaries: write 0xDEAD to COUNT and to Addr[3:2]=3 -> no effect, reads return COUNT value and 0; Wr=0 with valid Addr/WD -> no register changes; PRESET=0 -> IRQ 3 cycles after enable write.
